// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the modulator FIFO read/write controllers.
// Gray conversions run at a fixed maximum width; callers cast to their own.
package fifo_pkg;

   localparam int PTR_MAX_W = 16;
   localparam int SYNC_MAX  = 3;

   function automatic bit sync_legal(input int stages);
      return (stages == 0) || ((stages >= 2) && (stages <= SYNC_MAX));
   endfunction

   function automatic logic [PTR_MAX_W-1:0] bin2gray(
      input logic [PTR_MAX_W-1:0] b
   );
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PTR_MAX_W-1:0] gray2bin(
      input logic [PTR_MAX_W-1:0] g
   );
      logic [PTR_MAX_W-1:0] b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_wr_ctrl_param_gray_sync.sv
// N-stage flop chain for a Gray pointer crossing; zero stages is a wire.
module gray_sync
   import fifo_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int STAGES = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   if (STAGES == 0) begin : g_pass
      logic w_unused;
      assign w_unused = clk ^ rst_n;
      assign o_q      = i_d;
   end else begin : g_flops
      logic [WIDTH-1:0] r_sync [STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
         end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
         end
      end

      assign o_q = r_sync[STAGES-1];
   end

endmodule

// File: rtl/fifo_wr_ctrl_param.sv
// Write-side pointer/status controller: Gray write pointer out, Gray read
// pointer in, registered full/almost_full/level and a sticky overflow.
module fifo_wr_ctrl_param
   import fifo_pkg::*;
#(
   parameter int ADDR_W      = 3,
   parameter int AF_LEVEL    = 6,
   parameter int SYNC_STAGES = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W:0]   rd_ptr_gray,
   input  logic              clr_ovf,
   output logic              wr_en_out,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W:0]   wr_ptr_gray,
   output logic              full,
   output logic              almost_full,
   output logic [ADDR_W:0]   wr_level,
   output logic              overflow
);

   localparam int PW = ADDR_W + 1;
   localparam logic [PW-1:0] AF_LVL = PW'(AF_LEVEL);

   if ((AF_LEVEL < 1) || (AF_LEVEL > (1 << ADDR_W))) begin : g_bad_af
      $error("fifo_wr_ctrl_param: AF_LEVEL out of range");
   end
   if (!sync_legal(SYNC_STAGES)) begin : g_bad_sync
      $error("fifo_wr_ctrl_param: illegal SYNC_STAGES");
   end
   if (PW > PTR_MAX_W) begin : g_bad_w
      $error("fifo_wr_ctrl_param: ADDR_W too wide");
   end

   logic [PW-1:0] r_wr_ptr_bin;
   logic [PW-1:0] r_wr_ptr_gray;
   logic [PW-1:0] r_wr_level;
   logic          r_full;
   logic          r_almost_full;
   logic          r_overflow;

   logic          w_accept;
   logic [PW-1:0] w_rd_sync;
   logic [PW-1:0] w_rd_bin;
   logic [PW-1:0] w_ptr_next;
   logic [PW-1:0] w_level_next;
   logic          w_full_next;

   gray_sync #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_rd_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (rd_ptr_gray),
      .o_q   (w_rd_sync)
   );

   assign w_accept     = wr_en & ~r_full;
   assign w_rd_bin     = PW'(gray2bin(PTR_MAX_W'(w_rd_sync)));
   assign w_ptr_next   = r_wr_ptr_bin + PW'(w_accept);
   assign w_level_next = w_ptr_next - w_rd_bin;

   // Same slot index, opposite lap bit: exactly one full depth apart.
   assign w_full_next =
      (w_ptr_next[ADDR_W-1:0] == w_rd_bin[ADDR_W-1:0]) &&
      (w_ptr_next[ADDR_W] != w_rd_bin[ADDR_W]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr_bin  <= '0;
         r_wr_ptr_gray <= '0;
         r_wr_level    <= '0;
         r_full        <= 1'b0;
         r_almost_full <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         r_wr_ptr_bin  <= w_ptr_next;
         r_wr_ptr_gray <= PW'(bin2gray(PTR_MAX_W'(w_ptr_next)));
         r_wr_level    <= w_level_next;
         r_full        <= w_full_next;
         r_almost_full <= (w_level_next >= AF_LVL);
         if (wr_en & r_full) r_overflow <= 1'b1;
         else if (clr_ovf)   r_overflow <= 1'b0;
      end
   end

   assign wr_en_out   = w_accept;
   assign wr_addr     = r_wr_ptr_bin[ADDR_W-1:0];
   assign wr_ptr_gray = r_wr_ptr_gray;
   assign full        = r_full;
   assign almost_full = r_almost_full;
   assign wr_level    = r_wr_level;
   assign overflow    = r_overflow;

endmodule
